// File: rtl/big_write_arbiter.sv
// rtl/big_write_arbiter.sv - slot-paced round-robin arbiter for the BIG memory write port
module big_write_arbiter #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 6,
    parameter int SLOT_PERIOD = 8,
    parameter int SLOT_PHASE  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    input  logic              req2,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] data2,
    output logic              ack0,
    output logic              ack1,
    output logic              ack2,
    output logic [ADDR_W-1:0] big_addr,
    output logic [DATA_W-1:0] big_data,
    output logic              big_we,
    output logic [1:0]        last_grant,
    output logic              busy
);

    // A one-bit counter is kept for SLOT_PERIOD == 1 so the vector never collapses to zero width.
    localparam int              CNT_W     = (SLOT_PERIOD > 1) ? $clog2(SLOT_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_PHASE = CNT_W'(SLOT_PHASE);

    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_ack;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_last_grant;
    logic              r_busy;

    logic [2:0]        w_req;
    logic [2:0]        w_cand;
    logic              w_slot;
    logic [1:0]        w_p0;
    logic [1:0]        w_p1;
    logic [1:0]        w_p2;
    logic              w_win_valid;
    logic [1:0]        w_win;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

    assign w_req  = {req2, req1, req0};
    // A requester whose ack is showing this cycle has just been served; it only
    // matters when slots are back to back, where it prevents a double write.
    assign w_cand = w_req & ~r_ack;
    assign w_slot = (r_cnt == CNT_PHASE);

    // Rotate the priority so the requester after the last winner comes first.
    always_comb begin
        w_p0 = 2'd0;
        w_p1 = 2'd1;
        w_p2 = 2'd2;
        case (r_last_grant)
            2'd0: begin
                w_p0 = 2'd1;
                w_p1 = 2'd2;
                w_p2 = 2'd0;
            end
            2'd1: begin
                w_p0 = 2'd2;
                w_p1 = 2'd0;
                w_p2 = 2'd1;
            end
            default: begin
                w_p0 = 2'd0;
                w_p1 = 2'd1;
                w_p2 = 2'd2;
            end
        endcase
    end

    // Pick the first candidate in rotated priority order.
    always_comb begin
        w_win_valid = 1'b0;
        w_win       = 2'd0;
        if (w_cand[w_p0]) begin
            w_win_valid = 1'b1;
            w_win       = w_p0;
        end else if (w_cand[w_p1]) begin
            w_win_valid = 1'b1;
            w_win       = w_p1;
        end else if (w_cand[w_p2]) begin
            w_win_valid = 1'b1;
            w_win       = w_p2;
        end
    end

    // Route the winner's address and data toward the output registers.
    always_comb begin
        w_sel_addr = addr2;
        w_sel_data = data2;
        case (w_win)
            2'd0: begin
                w_sel_addr = addr0;
                w_sel_data = data0;
            end
            2'd1: begin
                w_sel_addr = addr1;
                w_sel_data = data1;
            end
            default: begin
                w_sel_addr = addr2;
                w_sel_data = data2;
            end
        endcase
    end

    // Slot pacing, grant registration and single-cycle write/ack pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_ack        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_last_grant <= 2'd2;
            r_busy       <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
            r_busy <= |w_req;
            r_ack  <= '0;
            r_we   <= 1'b0;
            if (w_slot && w_win_valid) begin
                r_we         <= 1'b1;
                r_ack        <= 3'b001 << w_win;
                r_addr       <= w_sel_addr;
                r_data       <= w_sel_data;
                r_last_grant <= w_win;
            end
        end
    end

    assign ack0       = r_ack[0];
    assign ack1       = r_ack[1];
    assign ack2       = r_ack[2];
    assign big_we     = r_we;
    assign big_addr   = r_addr;
    assign big_data   = r_data;
    assign last_grant = r_last_grant;
    assign busy       = r_busy;

endmodule

// File: tb/tb_big_write_arbiter.sv
// tb/tb_big_write_arbiter.sv - self-checking bench for big_write_arbiter
module tb_big_write_arbiter;

    localparam logic [10:0] A0 = 11'h123;
    localparam logic [5:0]  D0 = 6'h15;
    localparam logic [10:0] A1 = 11'h2AA;
    localparam logic [5:0]  D1 = 6'h2A;
    localparam logic [10:0] A2 = 11'h7FF;
    localparam logic [5:0]  D2 = 6'h3F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [10:0] a0 = A0, a1 = A1, a2 = A2;
    logic [5:0]  d0 = D0, d1 = D1, d2 = D2;

    logic [2:0]  ack_a, ack_b;
    logic        we_a, we_b, busy_a, busy_b;
    logic [10:0] ba_a, ba_b;
    logic [5:0]  bd_a, bd_b;
    logic [1:0]  lg_a, lg_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    big_write_arbiter #(.ADDR_W(11), .DATA_W(6), .SLOT_PERIOD(8), .SLOT_PHASE(2)) u_a (
        .clk(clk), .rst(rst),
        .req0(req[0]), .addr0(a0), .data0(d0),
        .req1(req[1]), .addr1(a1), .data1(d1),
        .req2(req[2]), .addr2(a2), .data2(d2),
        .ack0(ack_a[0]), .ack1(ack_a[1]), .ack2(ack_a[2]),
        .big_addr(ba_a), .big_data(bd_a), .big_we(we_a),
        .last_grant(lg_a), .busy(busy_a)
    );

    big_write_arbiter #(.ADDR_W(11), .DATA_W(6), .SLOT_PERIOD(1), .SLOT_PHASE(0)) u_b (
        .clk(clk), .rst(rst),
        .req0(req[0]), .addr0(a0), .data0(d0),
        .req1(req[1]), .addr1(a1), .data1(d1),
        .req2(req[2]), .addr2(a2), .data2(d2),
        .ack0(ack_b[0]), .ack1(ack_b[1]), .ack2(ack_b[2]),
        .big_addr(ba_b), .big_data(bd_b), .big_we(we_b),
        .last_grant(lg_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the slot is found from cycles since reset modulo the
    // period, and the winner by scanning offsets 1..3 from the last grant.
    typedef struct {
        int          cyc;
        int          lg;
        logic [2:0]  ack;
        logic        we;
        logic [10:0] addr;
        logic [5:0]  data;
        logic        busy;
    } mst_t;

    mst_t m_a, m_b;
    bit   armed = 1'b0;

    function automatic mst_t step(input mst_t s, input int per, input int ph);
        mst_t        n;
        logic [10:0] aa [3];
        logic [5:0]  dd [3];
        bit          found;
        int          k;
        aa = '{a0, a1, a2};
        dd = '{d0, d1, d2};
        n = s;
        n.ack  = 3'b000;
        n.we   = 1'b0;
        n.busy = |req;
        if (rst) begin
            n.cyc  = 0;
            n.lg   = 2;
            n.addr = '0;
            n.data = '0;
            n.busy = 1'b0;
            return n;
        end
        found = 1'b0;
        if ((s.cyc % per) == ph) begin
            for (int j = 1; j <= 3; j++) begin
                k = (s.lg + j) % 3;
                if (!found && req[k] && !s.ack[k]) begin
                    found  = 1'b1;
                    n.ack[k] = 1'b1;
                    n.we   = 1'b1;
                    n.addr = aa[k];
                    n.data = dd[k];
                    n.lg   = k;
                end
            end
        end
        n.cyc = s.cyc + 1;
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) armed <= 1'b1;
        m_a <= step(m_a, 8, 2);
        m_b <= step(m_b, 1, 0);
    end

    task automatic cmp_dut(input string n, input mst_t m, input logic [2:0] ack, input logic we,
                           input logic [10:0] ba, input logic [5:0] bd, input logic [1:0] lg,
                           input logic busy);
        check({n, ".ack"}, 32'(ack), 32'(m.ack));
        check({n, ".we"}, 32'(we), 32'(m.we));
        check({n, ".addr"}, 32'(ba), 32'(m.addr));
        check({n, ".data"}, 32'(bd), 32'(m.data));
        check({n, ".last_grant"}, 32'(lg), 32'(m.lg));
        check({n, ".busy"}, 32'(busy), 32'(m.busy));
    endtask

    always @(negedge clk) begin
        if (armed) begin
            cmp_dut("model_a", m_a, ack_a, we_a, ba_a, bd_a, lg_a, busy_a);
            cmp_dut("model_b", m_b, ack_b, we_b, ba_b, bd_b, lg_b, busy_b);
        end
    end

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [2:0]  ack;
        logic [10:0] addr;
        logic [5:0]  data;
        logic [1:0]  lg;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [2:0] q, input logic [2:0] k,
                       input logic [10:0] ad, input logic [5:0] dt, input logic [1:0] g, input int cnt);
        vec_t v;
        v.rst = r; v.req = q; v.ack = k; v.addr = ad; v.data = dt; v.lg = g;
        for (int i = 0; i < cnt; i++) tbl.push_back(v);
    endtask

    int          ack_idx[$];
    int          ack_cyc[$];
    int          idx;
    logic [2:0]  r3;

    initial begin
        // Directed table on the period-8 instance: {rst, req, expected ack, addr, data, last_grant}.
        add(1, 3'b000, 3'b000, 11'h0, 6'h0, 2, 1);  // reset
        add(0, 3'b001, 3'b000, 11'h0, 6'h0, 2, 2);  // req0 from counter 0
        add(0, 3'b001, 3'b001, A0, D0, 0, 1);       // slot: ack0
        add(0, 3'b000, 3'b000, A0, D0, 0, 1);       // single pulse only
        add(0, 3'b010, 3'b000, A0, D0, 0, 6);
        add(0, 3'b010, 3'b010, A1, D1, 1, 1);       // grant 1
        add(0, 3'b101, 3'b000, A1, D1, 1, 7);       // req0 and req2 contend
        add(0, 3'b101, 3'b100, A2, D2, 2, 1);       // req2 first after grant 1
        add(0, 3'b001, 3'b000, A2, D2, 2, 7);
        add(0, 3'b001, 3'b001, A0, D0, 0, 1);       // req0 one slot later
        add(0, 3'b000, 3'b000, A0, D0, 0, 5);
        add(0, 3'b010, 3'b000, A0, D0, 0, 1);       // req1 at counter 0
        add(0, 3'b000, 3'b000, A0, D0, 0, 9);       // withdrawn: no write at slot
        add(1, 3'b001, 3'b000, 11'h0, 6'h0, 2, 1);  // reset on a slot cycle
        add(0, 3'b001, 3'b000, 11'h0, 6'h0, 2, 2);
        add(0, 3'b001, 3'b001, A0, D0, 0, 1);       // counter restarted at 0
        add(0, 3'b000, 3'b000, A0, D0, 0, 1);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst;
            req = tbl[i].req;
            @(negedge clk);
            check($sformatf("tbl[%0d].ack", i), 32'(ack_a), 32'(tbl[i].ack));
            check($sformatf("tbl[%0d].we", i), 32'(we_a), 32'(|tbl[i].ack));
            check($sformatf("tbl[%0d].addr", i), 32'(ba_a), 32'(tbl[i].addr));
            check($sformatf("tbl[%0d].data", i), 32'(bd_a), 32'(tbl[i].data));
            check($sformatf("tbl[%0d].lg", i), 32'(lg_a), 32'(tbl[i].lg));
        end

        // Full contention: all requesters held, each dropped during its own ack cycle.
        rst = 1'b1; req = 3'b000;
        @(negedge clk);
        rst = 1'b0; req = 3'b111;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            check("contention.onehot", 32'($countones(ack_a) <= 1), 32'd1);
            if (ack_a != 3'b000) begin
                idx = ack_a[1] ? 1 : (ack_a[2] ? 2 : 0);
                ack_idx.push_back(idx);
                ack_cyc.push_back(c);
                check("contention.addr", 32'(ba_a), (idx == 0) ? 32'(A0) : (idx == 1) ? 32'(A1) : 32'(A2));
            end
            req = 3'b111 & ~ack_a;
        end
        check("contention.count", 32'(ack_idx.size()), 32'd6);
        for (int i = 0; i < ack_idx.size() && i < 6; i++) begin
            check($sformatf("contention.order[%0d]", i), 32'(ack_idx[i]), 32'(i % 3));
            check($sformatf("contention.cycle[%0d]", i), 32'(ack_cyc[i]), 32'(2 + 8 * i));
        end

        // Back-to-back slots on the period-1 instance: req0 alone for 6 cycles.
        rst = 1'b1; req = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            req = (k < 6) ? 3'b001 : 3'b000;
            @(negedge clk);
            check($sformatf("b2b.ack0[%0d]", k + 1), 32'(ack_b[0]), 32'((k % 2) == 0 && k < 6));
            check($sformatf("b2b.we[%0d]", k + 1), 32'(we_b), 32'((k % 2) == 0 && k < 6));
        end

        // Randomized traffic, checked every cycle against the reference model.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            r3  = 3'($urandom);
            req = ($urandom_range(0, 3) == 0) ? 3'b000 : r3;
            a0 = 11'($urandom); a1 = 11'($urandom); a2 = 11'($urandom);
            d0 = 6'($urandom);  d1 = 6'($urandom);  d2 = 6'($urandom);
            @(negedge clk);
        end
        rst = 1'b0;
        req = 3'b000;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
